// File: rtl/race_seq_pkg.sv
// Shared types and defaults for the race_seq_ctrl lockstep counter-pair sequencer.
package race_seq_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default width of the mismatch counter.
    localparam int ERR_W_DEFAULT = 16;

endpackage

// File: rtl/race_seq_ctrl_if.sv
// Control/status bundle between a driver (master) and race_seq_ctrl (slave).
interface race_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
);
    logic             start;
    logic             abort;
    logic             inject;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count1;
    logic [WIDTH-1:0] count2;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output start, abort, inject,
        input  busy, done, count1, count2, mismatch, err_cnt
    );

    modport slave (
        input  start, abort, inject,
        output busy, done, count1, count2, mismatch, err_cnt
    );
endinterface

// File: rtl/race_seq_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value
);
    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    // Clear wins over increment; increment stops once every bit is set.
    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && (value_q != {W{1'b1}})) begin
            value_d = value_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/race_seq_ctrl.sv
// race_seq_ctrl: runs NUM_TESTS lockstep compares of a producer counter (count1)
// against a lagging checker counter (count2), counting mismatches in err_cnt.
// Optional build macro RACE_SEQ_STOP_ON_ERR_EN: the first failed compare ends
// the run early (DONE at the next edge) instead of running all compares.
module race_seq_ctrl
    import race_seq_pkg::*;
#(
    parameter int NUM_TESTS = 100,
    parameter int WIDTH     = 8,
    parameter int ERR_W     = ERR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    race_seq_ctrl_if.slave  bus
);
    localparam int                TICK_W    = $clog2(NUM_TESTS + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NUM_TESTS - 1);

    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [WIDTH-1:0]  count1_q, count1_d;
    logic [WIDTH-1:0]  count2_q, count2_d;
    logic [WIDTH-1:0]  count2_inc;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mismatch_q, mismatch_d;
    logic              fail;
    logic              err_clr;
    logic              err_inc;

    // Checker expects count1 to lead count2 by exactly one, modulo 2^WIDTH.
    assign count2_inc = count2_q + WIDTH'(1);
    assign fail       = (count1_q != count2_inc);

    // Next-state and output decode for the sequencer.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        count1_d   = count1_q;
        count2_d   = count2_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mismatch_d = 1'b0;
        err_clr    = 1'b0;
        err_inc    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    count1_d = WIDTH'(1);
                    count2_d = '0;
                    tick_d   = '0;
                    err_clr  = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    busy_d     = 1'b1;
                    count2_d   = count2_inc;
                    tick_d     = tick_q + TICK_W'(1);
                    mismatch_d = fail;
                    err_inc    = fail;
                    // On the final compare count1 holds so the pair ends equal.
                    if (tick_q < TICK_LAST) begin
                        count1_d = count1_q + (bus.inject ? WIDTH'(2) : WIDTH'(1));
                    end
                    if (tick_q == TICK_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`ifdef RACE_SEQ_STOP_ON_ERR_EN
                    if (fail) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`else
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            count1_q   <= '0;
            count2_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            count1_q   <= count1_d;
            count2_q   <= count2_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (err_clr),
        .inc   (err_inc),
        .value (bus.err_cnt)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mismatch = mismatch_q;
    assign bus.count1   = count1_q;
    assign bus.count2   = count2_q;
endmodule

// File: tb/tb_race_seq_ctrl.sv
// Directed bench for race_seq_ctrl: default instance plus a WIDTH=4/NUM_TESTS=20 wrap instance.
module tb_race_seq_ctrl;
    logic clk;
    logic rst_n;

    race_seq_ctrl_if #(.WIDTH(8), .ERR_W(16)) aif ();
    race_seq_ctrl_if #(.WIDTH(4), .ERR_W(16)) bif ();

    race_seq_ctrl #(.NUM_TESTS(100), .WIDTH(8), .ERR_W(16)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (aif.slave)
    );

    race_seq_ctrl #(.NUM_TESTS(20), .WIDTH(4), .ERR_W(16)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic busy_h  [256];
    logic done_h  [256];
    logic mism_h  [256];
    logic bdone_h [256];

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int first_set(input logic h [256], input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (h[i] === 1'b1) return i;
        return -1;
    endfunction

    function automatic int first_clr(input logic h [256], input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (h[i] !== 1'b1) return i;
        return -1;
    endfunction

    function automatic int count_set(input logic h [256], input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (h[i] === 1'b1) n++;
        return n;
    endfunction

    // Raise start ahead of edge 0; returns at the negedge inside cycle 1.
    task automatic begin_run(input logic also_b);
        @(negedge clk);
        aif.start = 1'b1;
        bif.start = also_b;
        @(negedge clk);
        aif.start = 1'b0;
        bif.start = 1'b0;
    endtask

    // At the negedge of cycles 1..max_cyc: record outputs, then drive inputs for that cycle's edge.
    task automatic observe(input int max_cyc, input logic hold_start, input int inj_cyc, input int abt_cyc);
        for (int c = 1; c <= max_cyc; c++) begin
            busy_h[c]  = aif.busy;
            done_h[c]  = aif.done;
            mism_h[c]  = aif.mismatch;
            bdone_h[c] = bif.done;
            aif.start  = hold_start;
            aif.inject = (c == inj_cyc);
            aif.abort  = (c == abt_cyc);
            if (c < max_cyc) @(negedge clk);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        aif.start  = 1'b0;
        aif.abort  = 1'b0;
        aif.inject = 1'b0;
        bif.start  = 1'b0;
        bif.abort  = 1'b0;
        bif.inject = 1'b0;

        // Reset state
        #12;
        check_val("rst_busy", aif.busy, 0);
        check_val("rst_done", aif.done, 0);
        check_val("rst_count1", aif.count1, 0);
        check_val("rst_err", aif.err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean default run, wrap instance started alongside
        begin_run(1'b1);
        observe(101, 1'b0, 0, 0);
        check_val("t1_busy_cycles", count_set(busy_h, 1, 100), 100);
        check_val("t1_busy_low", first_clr(busy_h, 1, 101), 101);
        check_val("t1_done_cyc", first_set(done_h, 1, 101), 101);
        check_val("t1_done_cnt", count_set(done_h, 1, 101), 1);
        check_val("t1_mism_cnt", count_set(mism_h, 1, 101), 0);
        check_val("t1_count1", aif.count1, 100);
        check_val("t1_count2", aif.count2, 100);
        check_val("t1_err", aif.err_cnt, 0);
        check_val("wrap_done_cyc", first_set(bdone_h, 1, 101), 21);
        check_val("wrap_count1", bif.count1, 4);
        check_val("wrap_count2", bif.count2, 4);
        check_val("wrap_err", bif.err_cnt, 0);
        @(negedge clk);
        check_val("t1_done_drop", aif.done, 0);

        // Fault injected in RUN cycle 10
        begin_run(1'b0);
        observe(101, 1'b0, 10, 0);
        aif.inject = 1'b0;
        check_val("inj_mism_first", first_set(mism_h, 1, 101), 12);
`ifdef RACE_SEQ_STOP_ON_ERR_EN
        check_val("inj_mism_cnt", count_set(mism_h, 1, 101), 1);
        check_val("inj_done_cyc", first_set(done_h, 1, 101), 12);
        check_val("inj_err", aif.err_cnt, 1);
`else
        check_val("inj_mism_cnt", count_set(mism_h, 1, 101), 90);
        check_val("inj_done_cyc", first_set(done_h, 1, 101), 101);
        check_val("inj_err", aif.err_cnt, 90);
        check_val("inj_count1", aif.count1, 101);
        check_val("inj_count2", aif.count2, 100);
`endif
        @(negedge clk);
        @(negedge clk);

        // Abort in RUN cycle 50
        begin_run(1'b0);
        observe(55, 1'b0, 0, 50);
        check_val("abt_busy_low", first_clr(busy_h, 1, 55), 51);
        check_val("abt_done_cnt", count_set(done_h, 1, 55), 0);
        check_val("abt_count1", aif.count1, 50);
        check_val("abt_count2", aif.count2, 49);
        check_val("abt_err", aif.err_cnt, 0);

        // start held high through a whole run
        begin_run(1'b0);
        observe(103, 1'b1, 0, 0);
        check_val("hold_done_cnt", count_set(done_h, 1, 102), 1);
        check_val("hold_done_cyc", first_set(done_h, 1, 102), 101);
        check_val("hold_idle_gap", busy_h[102], 0);
        check_val("hold_restart", busy_h[103], 1);
        aif.start = 1'b0;
        aif.abort = 1'b1;
        @(negedge clk);
        aif.abort = 1'b0;
        check_val("hold_abort2", aif.busy, 0);
        @(negedge clk);

        // start with abort in IDLE stays idle
        aif.start = 1'b1;
        aif.abort = 1'b1;
        @(negedge clk);
        check_val("sa_busy", aif.busy, 0);
        @(negedge clk);
        check_val("sa_busy2", aif.busy, 0);
        aif.start = 1'b0;
        aif.abort = 1'b0;
        @(negedge clk);

        // Async reset during RUN cycle 30
        begin_run(1'b0);
        observe(30, 1'b0, 0, 0);
        check_val("mid_busy_pre", aif.busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", aif.busy, 0);
        check_val("mid_rst_done", aif.done, 0);
        check_val("mid_rst_mism", aif.mismatch, 0);
        check_val("mid_rst_count1", aif.count1, 0);
        check_val("mid_rst_count2", aif.count2, 0);
        check_val("mid_rst_err", aif.err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin_run(1'b0);
        observe(102, 1'b0, 0, 0);
        check_val("post_done_cyc", first_set(done_h, 1, 102), 101);
        check_val("post_count1", aif.count1, 100);
        check_val("post_err", aif.err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/race_seq_ctrl.md
# race_seq_ctrl

Synthesizable sequencer for the lockstep counter-pair check used by the race examples. The block runs a fixed number of test cycles and advances a producer counter (count1) and a lagging checker counter (count2) in a fixed, race-free order from one clock edge. It compares the two counters every cycle, accumulates mismatches, and signals completion with a start/done handshake. It replaces the clock-generator/initial-block harness with a deterministic controller that a bench or top level can drive.

## Interface
- NUM_TESTS, 100: number of compare cycles per run; must be ≥1.
- WIDTH, 8: width of count1/count2.
- ERR_W, 16: width of the mismatch counter.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled in IDLE only.
- abort  in  1  terminates a run, no done pulse.
- inject  in  1  fault injection: count1 steps +2 instead of +1 this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.
- count1  out  WIDTH  producer counter.
- count2  out  WIDTH  checker counter.
- mismatch  out  1  registered, high the cycle after a failed compare.
- err_cnt  out  ERR_W  mismatches in the current or last run; saturates at all ones.

## Operation
- Reset: state IDLE; all outputs 0; internal tick counter 0.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 and abort=0, go to RUN with count1<=1, count2<=0, err_cnt<=0, tick<=0. If start and abort are both 1, stay in IDLE. Counters hold their last values otherwise.
- RUN, per cycle in priority order:
  - abort=1: go to IDLE. No counter, error, or done update.
  - Otherwise compare: fail when count1 != count2+1 (mod 2^WIDTH). Then count2<=count2+1 and tick<=tick+1.
  - If tick < NUM_TESTS-1: count1 <= count1 + 1 + inject. On the last cycle inject is ignored and count1 holds.
  - On a fail, mismatch<=1 and err_cnt increments, saturating. Otherwise mismatch<=0.
  - When tick reaches NUM_TESTS-1, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- start while busy is ignored and is not queued.
- Counters wrap modulo 2^WIDTH, so NUM_TESTS > 2^WIDTH produces no false mismatch.
- tick width is $clog2(NUM_TESTS+1).

## Timing
- Start sampled at edge 0. RUN occupies cycles 1..NUM_TESTS, done is high in cycle NUM_TESTS+1, busy is low again from cycle NUM_TESTS+1.
- mismatch and err_cnt lag the failed compare by one edge.
- Async reset mid-run: every output is 0 immediately. No done pulse. Operation resumes in IDLE after rst_n deasserts, with a synchronous release.

## Configuration
- RACE_SEQ_STOP_ON_ERR_EN defined: the first failed compare sends RUN to DONE at the next edge instead of continuing. done pulses and err_cnt=1.
- RACE_SEQ_STOP_ON_ERR_EN undefined: all NUM_TESTS compares run regardless of failures.

## Structure
- Package race_seq_pkg holds the state enum (IDLE, RUN, DONE) and the default ERR_W constant.
- One sub-module, sat_counter (parameter width; clear, increment, saturating value). It is instantiated for err_cnt.
- The FSM, lockstep counters and comparator stay in race_seq_ctrl.

## Test plan
- Defaults, reset, then a one-cycle start → busy for cycles 1–100, done pulse in cycle 101, count1=count2=100, err_cnt=0, mismatch never high.
- WIDTH=4, NUM_TESTS=20 → wrap exercised, final count1=count2=4, err_cnt=0.
- Defaults, inject high in RUN cycle 10 only → mismatch high from cycle 12 onward, final err_cnt=90, count1=101, count2=100. With RACE_SEQ_STOP_ON_ERR_EN: done in cycle 12, err_cnt=1.
- abort in RUN cycle 50 → busy low from cycle 51, no done pulse, count1=50, count2=49.
- start held high through a run → exactly one run, and a new run starts the cycle after done. start and abort together in IDLE → stays IDLE.
- rst_n low in RUN cycle 30 → all outputs 0 at once. A later start runs cleanly to err_cnt=0.
